data_mem_responder: RTL



---
 rtl/data_mem_responder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the CPU data-memory port.
// One request at a time over valid/ready. The responder waits LATENCY
// cycles, then returns load data or a store acknowledgement with an error flag.
// The store or load is committed on the edge that enters RESP, so a dropped
// (reset) transaction never touches memory.
// Optional feature macro: DMEM_MISALIGN_ERR_EN. When it is defined, a
// non-word-aligned address is reported as an error and no access is made.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Countdown start value. It is only used when LATENCY > 0.
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

`ifdef DMEM_MISALIGN_ERR_EN
  localparam bit MISALIGN_CHK = 1'b1;
`else
  localparam bit MISALIGN_CHK = 1'b0;
`endif

  // Control state
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Request captured at acceptance. This is data only, so it has no reset.
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  // Backing store. It is never cleared.
  logic [31:0] mem_q [DEPTH_WORDS];

  // Request being committed. When LATENCY is 0 the live request is
  // committed on its acceptance edge. Otherwise the latched copy is used.
  logic          c_write;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [3:0]    c_wstrb;
  logic [AW-1:0] c_idx;
  logic          c_oor;
  logic          c_mis;
  logic          c_err;
  logic [31:0]   rd_word;
  logic          commit;
  logic          mem_we;

  // Merge the enabled byte lanes of the new data into the old word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Select which request is being committed this cycle.
  always_comb begin
    c_write = wr_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_wstrb = wstrb_q;
    if (state_q == S_IDLE) begin
      c_write = req_write;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_wstrb = req_wstrb;
    end
  end

  // Decode the address: word index, out-of-range check, optional misalignment.
  always_comb begin
    c_idx   = c_addr[AW+1:2];
    c_oor   = (c_addr >> (AW + 2)) != 32'd0;
    c_mis   = MISALIGN_CHK && (c_addr[1:0] != 2'b00);
    c_err   = c_oor || c_mis;
    rd_word = mem_q[c_idx];
  end

  // Next-state, countdown and response data logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (commit) begin
      err_d   = c_err;
      rdata_d = (c_write || c_err) ? 32'd0 : rd_word;
    end
  end

  // A store is written only on a committing edge. The !rst term stops a
  // request that is present while reset is held from reaching memory.
  assign mem_we = commit && c_write && !c_err && !rst;

  // Control registers, with asynchronous reset back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Capture the request fields on acceptance.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req_valid) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
    end
  end

  // Memory write port. A byte-lane merge is applied on store commit.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[c_idx] <= merge_lanes(rd_word, c_wdata, c_wstrb);
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
